// File: rtl/fetch_unit.sv
// fetch_unit: PC register, IF/ID pipeline latch and halt-on-JMP-(-1) detection.
// Define FETCH_JMP_PREDECODE_EN to redirect unconditional JMPs in fetch instead of passing them on.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter logic [31:0] HALT_WORD = 32'hA800FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Instruction,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] PC,
    output logic [31:0] IF_ID_Instruction,
    output logic [31:0] IF_ID_PC_plus4,
    output logic        IF_ID_valid,
    output logic        halted
);
    typedef enum logic {FETCH, HALT} state_t;
    state_t state;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;
    logic        is_jmp;
    assign pc_plus4 = PC + 32'd4;
`ifdef FETCH_JMP_PREDECODE_EN
    assign is_jmp  = Instruction[31:26] == 6'b101010;
    assign next_pc = is_jmp ? pc_plus4 + {{14{Instruction[15]}}, Instruction[15:0], 2'b00} : pc_plus4;
`else
    assign is_jmp  = 1'b0;
    assign next_pc = pc_plus4;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= FETCH;
            PC                <= RESET_PC;
            IF_ID_Instruction <= 32'd0;
            IF_ID_PC_plus4    <= 32'd0;
            IF_ID_valid       <= 1'b0;
            halted            <= 1'b0;
        end else if (state == FETCH) begin
            if (branch_taken) begin
                PC                <= branch_target & 32'hFFFF_FFFC;
                IF_ID_Instruction <= 32'd0;
                IF_ID_valid       <= 1'b0;
            end else if (Instruction == HALT_WORD && !stall) begin
                // PC is left on the halt word so a debugger sees where fetch stopped
                state             <= HALT;
                halted            <= 1'b1;
                IF_ID_Instruction <= 32'd0;
                IF_ID_valid       <= 1'b0;
            end else if (!stall) begin
                PC                <= next_pc;
                IF_ID_Instruction <= is_jmp ? 32'd0 : Instruction;
                IF_ID_PC_plus4    <= pc_plus4;
                IF_ID_valid       <= !is_jmp;
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized stimulus against a behavioural fetch model.
module tb_fetch_unit;
    localparam logic [31:0] HALT = 32'hA800FFFF;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] Instruction;
    logic [31:0] PC, IF_ID_Instruction, IF_ID_PC_plus4;
    logic        IF_ID_valid, halted;
    logic [31:0] rom [128];
    logic [31:0] m_pc, m_ir, m_p4;
    logic        m_v, m_halt;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;
    assign Instruction = rom[PC[8:2]];

    fetch_unit dut (
        .clk(clk), .rst(rst), .Instruction(Instruction), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .PC(PC),
        .IF_ID_Instruction(IF_ID_Instruction), .IF_ID_PC_plus4(IF_ID_PC_plus4),
        .IF_ID_valid(IF_ID_valid), .halted(halted)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: fetch behaviour expressed directly from the rules, one step per rising edge
    task automatic model_step();
        logic [31:0] w;
        w = rom[m_pc[8:2]];
        if (rst) begin
            m_pc = 32'd0; m_ir = 32'd0; m_p4 = 32'd0; m_v = 1'b0; m_halt = 1'b0;
        end else if (!m_halt) begin
            if (branch_taken) begin
                m_pc = {branch_target[31:2], 2'b00}; m_ir = 32'd0; m_v = 1'b0;
            end else if (w == HALT && !stall) begin
                m_halt = 1'b1; m_ir = 32'd0; m_v = 1'b0;
            end else if (!stall) begin
                m_p4 = m_pc + 32'd4;
`ifdef FETCH_JMP_PREDECODE_EN
                if (w[31:26] == 6'b101010) begin
                    m_pc = m_p4 + 32'($signed(w[15:0]) * 4); m_ir = 32'd0; m_v = 1'b0;
                end else begin
                    m_pc = m_p4; m_ir = w; m_v = 1'b1;
                end
`else
                m_pc = m_p4; m_ir = w; m_v = 1'b1;
`endif
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("pc", PC, m_pc);
        check("ir", IF_ID_Instruction, m_ir);
        check("p4", IF_ID_PC_plus4, m_p4);
        check("valid", {31'd0, IF_ID_valid}, {31'd0, m_v});
        check("halted", {31'd0, halted}, {31'd0, m_halt});
    endtask

    task automatic go(input logic r, input logic s, input logic b, input logic [31:0] t);
        rst = r; stall = s; branch_taken = b; branch_target = t;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 32'h1000_0000 + i;
        rom[0] = 32'h8001060A;
        rom[1] = 32'h04011000;
        rom[16] = 32'hA8000003;
        rom[63] = HALT;
        m_pc = 32'd0; m_ir = 32'd0; m_p4 = 32'd0; m_v = 1'b0; m_halt = 1'b0;
        // reset and first fetch
        go(1, 0, 0, 0);
        go(1, 1, 1, 32'h20);
        check("rst_pc", PC, 32'd0);
        check("rst_valid", {31'd0, IF_ID_valid}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        go(0, 0, 0, 0);
        check("first_ir", IF_ID_Instruction, 32'h8001060A);
        check("first_p4", IF_ID_PC_plus4, 32'd4);
        check("first_valid", {31'd0, IF_ID_valid}, 32'd1);
        check("first_pc", PC, 32'd4);
        // stall at PC=8
        go(0, 0, 0, 0);
        go(0, 1, 0, 0);
        go(0, 1, 0, 0);
        check("stall_pc", PC, 32'd8);
        check("stall_ir", IF_ID_Instruction, 32'h04011000);
        go(0, 0, 0, 0);
        check("unstall_pc", PC, 32'd12);
        // branch overrides stall, low address bits dropped
        go(0, 0, 1, 32'h30);
        go(0, 1, 1, 32'h3B);
        check("br_pc", PC, 32'h38);
        check("br_valid", {31'd0, IF_ID_valid}, 32'd0);
        go(0, 0, 0, 0);
        check("br_next_valid", {31'd0, IF_ID_valid}, 32'd1);
        check("br_next_p4", IF_ID_PC_plus4, 32'h3C);
        // halt at 252, branch ignored, reset exits
        go(0, 0, 1, 32'd252);
        go(0, 0, 0, 0);
        check("halt_flag", {31'd0, halted}, 32'd1);
        check("halt_pc", PC, 32'd252);
        check("halt_valid", {31'd0, IF_ID_valid}, 32'd0);
        go(0, 1, 1, 32'h0);
        check("halt_br_pc", PC, 32'd252);
        go(1, 0, 0, 0);
        check("halt_rst_pc", PC, 32'd0);
        check("halt_rst_flag", {31'd0, halted}, 32'd0);
        // JMP handling
        go(0, 0, 1, 32'h40);
        go(0, 0, 0, 0);
`ifdef FETCH_JMP_PREDECODE_EN
        check("jmp_pc", PC, 32'h50);
        check("jmp_valid", {31'd0, IF_ID_valid}, 32'd0);
`else
        check("jmp_pc", PC, 32'h44);
        check("jmp_valid", {31'd0, IF_ID_valid}, 32'd1);
        check("jmp_ir", IF_ID_Instruction, 32'hA8000003);
`endif
        // wrap at top of address space
        go(0, 0, 1, 32'hFFFF_FFFC);
        go(0, 0, 0, 0);
        check("wrap_pc", PC, 32'd0);
        check("wrap_p4", IF_ID_PC_plus4, 32'd0);
        // randomized run
        for (int i = 0; i < 128; i++) begin
            case ($urandom_range(0, 15))
                0: rom[i] = HALT;
                1, 2: rom[i] = {6'b101010, 10'($urandom), 16'($urandom_range(0, 8)) - 16'd4};
                default: rom[i] = $urandom;
            endcase
        end
        go(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            logic r, s, b;
            r = $urandom_range(0, 49) == 0;
            b = $urandom_range(0, 9) == 0;
            s = $urandom_range(0, 3) == 0;
            if (rom[m_pc[8:2]] == HALT) s = 1'b0;
            go(r, s, b, $urandom);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
